// File: rtl/e203_lsu_pkg.sv
// Shared definitions for the LSU region router: ICB size codes, outstanding-entry
// field widths and the load alignment/extension helper.
package e203_lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned OFS_W  = 2;

    typedef enum logic [SIZE_W-1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2
    } icb_size_e;

    // Index width needed to name one of ntgt targets (at least one bit).
    function automatic int unsigned tgt_idx_w(input int unsigned ntgt);
        return (ntgt > 1) ? $clog2(ntgt) : 1;
    endfunction

    // Align the returned word to the access offset, then zero/sign extend.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                    input logic [OFS_W-1:0] ofs,
                                                    input logic [SIZE_W-1:0] size,
                                                    input logic usign);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh = rdata >> {ofs, 3'b000};
        case (size)
            SizeByte: res = {{24{sh[7] & ~usign}}, sh[7:0]};
            SizeHalf: res = {{16{sh[15] & ~usign}}, sh[15:0]};
            default:  res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/e203_lsu_otf_fifo.sv
// Generic synchronous FIFO tracking in-flight LSU transactions. Pointers wrap
// modulo DEPTH, so non-power-of-two depths are supported.
module e203_lsu_otf_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (pop_ok) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/e203_lsu_rgn_router.sv
// LSU region router: decodes AGU commands onto NTGT ICB targets and returns
// responses strictly in order to the AGU or to the write-back port.
module e203_lsu_rgn_router
    import e203_lsu_pkg::*;
#(
    parameter int unsigned NTGT      = 3,
    parameter int unsigned OTF_DEPTH = 2,
    parameter int unsigned AW        = 32,
    parameter int unsigned ITAG_W    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NTGT*AW-1:0]   tgt_rgn_base,
    input  logic [NTGT*AW-1:0]   tgt_rgn_mask,
    output logic                 lsu_active,
    input  logic                 agu_icb_cmd_valid,
    output logic                 agu_icb_cmd_ready,
    input  logic [AW-1:0]        agu_icb_cmd_addr,
    input  logic                 agu_icb_cmd_read,
    input  logic [31:0]          agu_icb_cmd_wdata,
    input  logic [3:0]           agu_icb_cmd_wmask,
    input  logic                 agu_icb_cmd_lock,
    input  logic                 agu_icb_cmd_excl,
    input  logic [1:0]           agu_icb_cmd_size,
    input  logic                 agu_icb_cmd_back2agu,
    input  logic                 agu_icb_cmd_usign,
    input  logic [ITAG_W-1:0]    agu_icb_cmd_itag,
    output logic                 agu_icb_rsp_valid,
    input  logic                 agu_icb_rsp_ready,
    output logic                 agu_icb_rsp_err,
    output logic                 agu_icb_rsp_excl_ok,
    output logic [31:0]          agu_icb_rsp_rdata,
    output logic                 lsu_o_valid,
    input  logic                 lsu_o_ready,
    output logic [31:0]          lsu_o_wbck_wdat,
    output logic [ITAG_W-1:0]    lsu_o_wbck_itag,
    output logic                 lsu_o_wbck_err,
    output logic                 lsu_o_cmt_ld,
    output logic                 lsu_o_cmt_st,
    output logic                 lsu_o_cmt_buserr,
    output logic [AW-1:0]        lsu_o_cmt_badaddr,
    output logic [NTGT-1:0]      tgt_icb_cmd_valid,
    input  logic [NTGT-1:0]      tgt_icb_cmd_ready,
    output logic [NTGT*AW-1:0]   tgt_icb_cmd_addr,
    output logic [NTGT-1:0]      tgt_icb_cmd_read,
    output logic [NTGT-1:0]      tgt_icb_cmd_lock,
    output logic [NTGT-1:0]      tgt_icb_cmd_excl,
    output logic [NTGT*32-1:0]   tgt_icb_cmd_wdata,
    output logic [NTGT*4-1:0]    tgt_icb_cmd_wmask,
    output logic [NTGT*2-1:0]    tgt_icb_cmd_size,
    input  logic [NTGT-1:0]      tgt_icb_rsp_valid,
    output logic [NTGT-1:0]      tgt_icb_rsp_ready,
    input  logic [NTGT-1:0]      tgt_icb_rsp_err,
    input  logic [NTGT-1:0]      tgt_icb_rsp_excl_ok,
    input  logic [NTGT*32-1:0]   tgt_icb_rsp_rdata
);

    localparam int unsigned SEL_W = tgt_idx_w(NTGT);
    localparam int unsigned CNT_W = $clog2(OTF_DEPTH + 1);

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic              back2agu;
        logic              usign;
        logic [SIZE_W-1:0] size;
        logic [OFS_W-1:0]  ofs;
        logic              read;
        logic [ITAG_W-1:0] itag;
        logic [AW-1:0]     addr;
    } otf_entry_t;

    logic [SEL_W-1:0] sel;
    otf_entry_t       push_entry, head;
    logic             fifo_full, fifo_empty, push, pop;
    logic [CNT_W-1:0] fifo_count;
    logic             head_valid, head_err, head_excl_ok, dest_ready;
    logic [31:0]      head_rdata;

    // Lowest matching programmable region wins; no match falls to the default target.
    always_comb begin
        sel = SEL_W'(NTGT - 1);
        for (int i = int'(NTGT) - 2; i >= 0; i--) begin
            if ((agu_icb_cmd_addr & tgt_rgn_mask[i*AW +: AW]) ==
                (tgt_rgn_base[i*AW +: AW] & tgt_rgn_mask[i*AW +: AW])) begin
                sel = SEL_W'(i);
            end
        end
    end

    // Command path: payload broadcast, valid steered to the decoded target only.
    always_comb begin
        agu_icb_cmd_ready = 1'b0;
        for (int i = 0; i < int'(NTGT); i++) begin
            tgt_icb_cmd_valid[i] = agu_icb_cmd_valid & (sel == SEL_W'(i));
            if (sel == SEL_W'(i)) agu_icb_cmd_ready = tgt_icb_cmd_ready[i] & ~fifo_full;
        end
    end

    assign tgt_icb_cmd_addr  = {NTGT{agu_icb_cmd_addr}};
    assign tgt_icb_cmd_read  = {NTGT{agu_icb_cmd_read}};
    assign tgt_icb_cmd_lock  = {NTGT{agu_icb_cmd_lock}};
    assign tgt_icb_cmd_excl  = {NTGT{agu_icb_cmd_excl}};
    assign tgt_icb_cmd_wdata = {NTGT{agu_icb_cmd_wdata}};
    assign tgt_icb_cmd_wmask = {NTGT{agu_icb_cmd_wmask}};
    assign tgt_icb_cmd_size  = {NTGT{agu_icb_cmd_size}};

    assign push = agu_icb_cmd_valid & agu_icb_cmd_ready;

    assign push_entry = '{
        sel:      sel,
        back2agu: agu_icb_cmd_back2agu,
        usign:    agu_icb_cmd_usign,
        size:     agu_icb_cmd_size,
        ofs:      agu_icb_cmd_addr[1:0],
        read:     agu_icb_cmd_read,
        itag:     agu_icb_cmd_itag,
        addr:     agu_icb_cmd_addr
    };

    e203_lsu_otf_fifo #(
        .WIDTH ($bits(otf_entry_t)),
        .DEPTH (OTF_DEPTH)
    ) u_otf_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign dest_ready = head.back2agu ? agu_icb_rsp_ready : lsu_o_ready;

    // Response path: only the head entry's target may hand over a response.
    always_comb begin
        head_valid   = 1'b0;
        head_err     = 1'b0;
        head_excl_ok = 1'b0;
        head_rdata   = '0;
        for (int i = 0; i < int'(NTGT); i++) begin
            tgt_icb_rsp_ready[i] = ~fifo_empty & (head.sel == SEL_W'(i)) & dest_ready;
            if (head.sel == SEL_W'(i)) begin
                head_valid   = ~fifo_empty & tgt_icb_rsp_valid[i];
                head_err     = tgt_icb_rsp_err[i];
                head_excl_ok = tgt_icb_rsp_excl_ok[i];
                head_rdata   = tgt_icb_rsp_rdata[i*32 +: 32];
            end
        end
    end

    assign pop = head_valid & dest_ready;

    assign agu_icb_rsp_valid   = head_valid & head.back2agu;
    assign agu_icb_rsp_err     = head_err;
    assign agu_icb_rsp_excl_ok = head_excl_ok;
    assign agu_icb_rsp_rdata   = head_rdata;

    assign lsu_o_valid       = head_valid & ~head.back2agu;
    assign lsu_o_wbck_wdat   = head.read ? load_extend(head_rdata, head.ofs, head.size, head.usign)
                                         : '0;
    assign lsu_o_wbck_itag   = head.itag;
    assign lsu_o_wbck_err    = head_err;
    assign lsu_o_cmt_buserr  = head_err;
    assign lsu_o_cmt_ld      = head.read;
    assign lsu_o_cmt_st      = ~head.read;
    assign lsu_o_cmt_badaddr = head.addr;

    assign lsu_active = agu_icb_cmd_valid | ~fifo_empty;

    // Default-target region registers are not decoded; occupancy is informational.
    logic unused_sigs;
    assign unused_sigs = ^{tgt_rgn_base[(NTGT-1)*AW +: AW], tgt_rgn_mask[(NTGT-1)*AW +: AW],
                           fifo_count};

endmodule

// File: tb/tb_e203_lsu_rgn_router.sv
// Directed bench for the LSU region router with a write-back scoreboard.
module tb_e203_lsu_rgn_router;

    localparam int unsigned NTGT = 3;
    localparam int unsigned OTF  = 2;
    localparam int unsigned AW   = 32;
    localparam int unsigned IW   = 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NTGT*AW-1:0]  tgt_rgn_base, tgt_rgn_mask;
    logic                lsu_active;
    logic                agu_icb_cmd_valid, agu_icb_cmd_ready;
    logic [AW-1:0]       agu_icb_cmd_addr;
    logic                agu_icb_cmd_read;
    logic [31:0]         agu_icb_cmd_wdata;
    logic [3:0]          agu_icb_cmd_wmask;
    logic                agu_icb_cmd_lock, agu_icb_cmd_excl;
    logic [1:0]          agu_icb_cmd_size;
    logic                agu_icb_cmd_back2agu, agu_icb_cmd_usign;
    logic [IW-1:0]       agu_icb_cmd_itag;
    logic                agu_icb_rsp_valid, agu_icb_rsp_ready;
    logic                agu_icb_rsp_err, agu_icb_rsp_excl_ok;
    logic [31:0]         agu_icb_rsp_rdata;
    logic                lsu_o_valid, lsu_o_ready;
    logic [31:0]         lsu_o_wbck_wdat;
    logic [IW-1:0]       lsu_o_wbck_itag;
    logic                lsu_o_wbck_err, lsu_o_cmt_ld, lsu_o_cmt_st, lsu_o_cmt_buserr;
    logic [AW-1:0]       lsu_o_cmt_badaddr;
    logic [NTGT-1:0]     tgt_icb_cmd_valid, tgt_icb_cmd_ready;
    logic [NTGT*AW-1:0]  tgt_icb_cmd_addr;
    logic [NTGT-1:0]     tgt_icb_cmd_read, tgt_icb_cmd_lock, tgt_icb_cmd_excl;
    logic [NTGT*32-1:0]  tgt_icb_cmd_wdata;
    logic [NTGT*4-1:0]   tgt_icb_cmd_wmask;
    logic [NTGT*2-1:0]   tgt_icb_cmd_size;
    logic [NTGT-1:0]     tgt_icb_rsp_valid, tgt_icb_rsp_ready;
    logic [NTGT-1:0]     tgt_icb_rsp_err, tgt_icb_rsp_excl_ok;
    logic [NTGT*32-1:0]  tgt_icb_rsp_rdata;

    typedef struct {
        logic [31:0]   wdat;
        logic          err;
        logic          ld;
        logic [AW-1:0] badaddr;
        logic [IW-1:0] itag;
    } lsu_exp_t;

    lsu_exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    e203_lsu_rgn_router #(
        .NTGT      (NTGT),
        .OTF_DEPTH (OTF),
        .AW        (AW),
        .ITAG_W    (IW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .tgt_rgn_base         (tgt_rgn_base),
        .tgt_rgn_mask         (tgt_rgn_mask),
        .lsu_active           (lsu_active),
        .agu_icb_cmd_valid    (agu_icb_cmd_valid),
        .agu_icb_cmd_ready    (agu_icb_cmd_ready),
        .agu_icb_cmd_addr     (agu_icb_cmd_addr),
        .agu_icb_cmd_read     (agu_icb_cmd_read),
        .agu_icb_cmd_wdata    (agu_icb_cmd_wdata),
        .agu_icb_cmd_wmask    (agu_icb_cmd_wmask),
        .agu_icb_cmd_lock     (agu_icb_cmd_lock),
        .agu_icb_cmd_excl     (agu_icb_cmd_excl),
        .agu_icb_cmd_size     (agu_icb_cmd_size),
        .agu_icb_cmd_back2agu (agu_icb_cmd_back2agu),
        .agu_icb_cmd_usign    (agu_icb_cmd_usign),
        .agu_icb_cmd_itag     (agu_icb_cmd_itag),
        .agu_icb_rsp_valid    (agu_icb_rsp_valid),
        .agu_icb_rsp_ready    (agu_icb_rsp_ready),
        .agu_icb_rsp_err      (agu_icb_rsp_err),
        .agu_icb_rsp_excl_ok  (agu_icb_rsp_excl_ok),
        .agu_icb_rsp_rdata    (agu_icb_rsp_rdata),
        .lsu_o_valid          (lsu_o_valid),
        .lsu_o_ready          (lsu_o_ready),
        .lsu_o_wbck_wdat      (lsu_o_wbck_wdat),
        .lsu_o_wbck_itag      (lsu_o_wbck_itag),
        .lsu_o_wbck_err       (lsu_o_wbck_err),
        .lsu_o_cmt_ld         (lsu_o_cmt_ld),
        .lsu_o_cmt_st         (lsu_o_cmt_st),
        .lsu_o_cmt_buserr     (lsu_o_cmt_buserr),
        .lsu_o_cmt_badaddr    (lsu_o_cmt_badaddr),
        .tgt_icb_cmd_valid    (tgt_icb_cmd_valid),
        .tgt_icb_cmd_ready    (tgt_icb_cmd_ready),
        .tgt_icb_cmd_addr     (tgt_icb_cmd_addr),
        .tgt_icb_cmd_read     (tgt_icb_cmd_read),
        .tgt_icb_cmd_lock     (tgt_icb_cmd_lock),
        .tgt_icb_cmd_excl     (tgt_icb_cmd_excl),
        .tgt_icb_cmd_wdata    (tgt_icb_cmd_wdata),
        .tgt_icb_cmd_wmask    (tgt_icb_cmd_wmask),
        .tgt_icb_cmd_size     (tgt_icb_cmd_size),
        .tgt_icb_rsp_valid    (tgt_icb_rsp_valid),
        .tgt_icb_rsp_ready    (tgt_icb_rsp_ready),
        .tgt_icb_rsp_err      (tgt_icb_rsp_err),
        .tgt_icb_rsp_excl_ok  (tgt_icb_rsp_excl_ok),
        .tgt_icb_rsp_rdata    (tgt_icb_rsp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [AW-1:0] addr, input logic rd, input logic [1:0] size,
                             input logic usign, input logic b2a, input logic [IW-1:0] itag);
        agu_icb_cmd_valid    = 1'b1;
        agu_icb_cmd_addr     = addr;
        agu_icb_cmd_read     = rd;
        agu_icb_cmd_size     = size;
        agu_icb_cmd_usign    = usign;
        agu_icb_cmd_back2agu = b2a;
        agu_icb_cmd_itag     = itag;
        #1;
    endtask

    task automatic respond(input int t, input logic [31:0] rdata, input logic err);
        tgt_icb_rsp_valid             = '0;
        tgt_icb_rsp_valid[t]          = 1'b1;
        tgt_icb_rsp_rdata[t*32 +: 32] = rdata;
        tgt_icb_rsp_err[t]            = err;
        #1;
    endtask

    task automatic expect_lsu(input logic [31:0] wdat, input logic err, input logic ld,
                              input logic [AW-1:0] badaddr, input logic [IW-1:0] itag);
        lsu_exp_t e;
        e.wdat = wdat; e.err = err; e.ld = ld; e.badaddr = badaddr; e.itag = itag;
        sb.push_back(e);
    endtask

    // Compare the current write-back beat against the scoreboard head.
    task automatic check_lsu(input string tag);
        lsu_exp_t e;
        chk({tag, "_valid"}, 32'(lsu_o_valid), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_wdat"}, lsu_o_wbck_wdat, e.wdat);
            chk({tag, "_err"}, 32'(lsu_o_wbck_err), 32'(e.err));
            chk({tag, "_buserr"}, 32'(lsu_o_cmt_buserr), 32'(e.err));
            chk({tag, "_ld"}, 32'(lsu_o_cmt_ld), 32'(e.ld));
            chk({tag, "_st"}, 32'(lsu_o_cmt_st), 32'(!e.ld));
            chk({tag, "_badaddr"}, lsu_o_cmt_badaddr, e.badaddr);
            chk({tag, "_itag"}, 32'(lsu_o_wbck_itag), 32'(e.itag));
        end
    endtask

    // One load to a single target, answered immediately, checked and retired.
    task automatic load_case(input string tag, input logic [AW-1:0] addr, input logic [1:0] size,
                             input logic usign, input int t, input logic [31:0] rdata,
                             input logic [31:0] exp);
        drive_cmd(addr, 1'b1, size, usign, 1'b0, 1'b1);
        chk({tag, "_cmd_ready"}, 32'(agu_icb_cmd_ready), 32'd1);
        tick();
        agu_icb_cmd_valid = 1'b0;
        expect_lsu(exp, 1'b0, 1'b1, addr, 1'b1);
        respond(t, rdata, 1'b0);
        check_lsu(tag);
        tick();
        tgt_icb_rsp_valid = '0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        tgt_rgn_base = '0;
        tgt_rgn_mask = '0;
        tgt_rgn_base[0*AW +: AW] = 32'h8000_0000;
        tgt_rgn_mask[0*AW +: AW] = 32'hFFFF_0000;
        tgt_rgn_base[1*AW +: AW] = 32'h9000_0000;
        tgt_rgn_mask[1*AW +: AW] = 32'hFFFF_0000;
        agu_icb_cmd_valid = 1'b0; agu_icb_cmd_addr = '0; agu_icb_cmd_read = 1'b0;
        agu_icb_cmd_wdata = '0; agu_icb_cmd_wmask = '0; agu_icb_cmd_lock = 1'b0;
        agu_icb_cmd_excl = 1'b0; agu_icb_cmd_size = 2'd2; agu_icb_cmd_back2agu = 1'b0;
        agu_icb_cmd_usign = 1'b0; agu_icb_cmd_itag = '0;
        agu_icb_rsp_ready = 1'b1; lsu_o_ready = 1'b1;
        tgt_icb_cmd_ready = '1;
        tgt_icb_rsp_valid = '1; tgt_icb_rsp_err = '0; tgt_icb_rsp_excl_ok = '0;
        tgt_icb_rsp_rdata = '0;

        // Reset state: stray target responses are held off while empty.
        tick(); tick();
        chk("rst_active", 32'(lsu_active), 32'd0);
        chk("rst_agu_rsp_valid", 32'(agu_icb_rsp_valid), 32'd0);
        chk("rst_lsu_valid", 32'(lsu_o_valid), 32'd0);
        chk("rst_rsp_ready", 32'(tgt_icb_rsp_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("empty_rsp_ready", 32'(tgt_icb_rsp_ready), 32'd0);
        tgt_icb_rsp_valid = '0;

        // Region decode without handshaking.
        drive_cmd(32'h8000_0004, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        chk("dec_rgn0", 32'(tgt_icb_cmd_valid), 32'b001);
        chk("dec_active", 32'(lsu_active), 32'd1);
        drive_cmd(32'h9000_0008, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        chk("dec_rgn1", 32'(tgt_icb_cmd_valid), 32'b010);
        drive_cmd(32'h1000_0000, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        chk("dec_default", 32'(tgt_icb_cmd_valid), 32'b100);
        tgt_icb_cmd_ready = 3'b011;
        #1;
        chk("dec_ready_follows_sel", 32'(agu_icb_cmd_ready), 32'd0);
        tgt_icb_cmd_ready = '1;
        agu_icb_cmd_valid = 1'b0;
        #1;
        chk("idle_active", 32'(lsu_active), 32'd0);

        // Ordering and full back-pressure.
        drive_cmd(32'h8000_0000, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        drive_cmd(32'h9000_0000, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
        chk("ord_second_ready", 32'(agu_icb_cmd_ready), 32'd1);
        tick();
        drive_cmd(32'h1000_0000, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        chk("full_bp", 32'(agu_icb_cmd_ready), 32'd0);
        respond(1, 32'h2222_2222, 1'b0);
        chk("ord_tgt1_held", 32'(tgt_icb_rsp_ready), 32'b001);
        chk("ord_lsu_idle", 32'(lsu_o_valid), 32'd0);
        expect_lsu(32'h1111_1111, 1'b0, 1'b1, 32'h8000_0000, 1'b0);
        tgt_icb_rsp_valid[0] = 1'b1;
        tgt_icb_rsp_rdata[31:0] = 32'h1111_1111;
        #1;
        chk("ord_head_ready", 32'(tgt_icb_rsp_ready), 32'b001);
        chk("no_bypass", 32'(agu_icb_cmd_ready), 32'd0);
        check_lsu("ord_first");
        tick();
        tgt_icb_rsp_valid[0] = 1'b0;
        expect_lsu(32'h2222_2222, 1'b0, 1'b1, 32'h9000_0000, 1'b1);
        #1;
        chk("ready_after_pop", 32'(agu_icb_cmd_ready), 32'd1);
        chk("ord_tgt1_ready", 32'(tgt_icb_rsp_ready), 32'b010);
        check_lsu("ord_second");
        tick();
        agu_icb_cmd_valid = 1'b0;
        tgt_icb_rsp_valid = '0;
        #1;
        chk("third_active", 32'(lsu_active), 32'd1);
        chk("third_head_ready", 32'(tgt_icb_rsp_ready), 32'b100);

        // Hold stability while the write-back port stalls.
        lsu_o_ready = 1'b0;
        respond(2, 32'hCAFE_F00D, 1'b0);
        chk("stall_rsp_ready", 32'(tgt_icb_rsp_ready), 32'b000);
        tick();
        chk("stall_valid", 32'(lsu_o_valid), 32'd1);
        chk("stall_wdat", lsu_o_wbck_wdat, 32'hCAFE_F00D);
        lsu_o_ready = 1'b1;
        expect_lsu(32'hCAFE_F00D, 1'b0, 1'b1, 32'h1000_0000, 1'b0);
        #1;
        check_lsu("third");
        tick();
        tgt_icb_rsp_valid = '0;
        #1;
        chk("drained_active", 32'(lsu_active), 32'd0);

        // Load alignment and extension.
        load_case("lb_ofs3", 32'h8000_0003, 2'd0, 1'b0, 0, 32'h80AB_CDEF, 32'hFFFF_FF80);
        load_case("lhu_ofs2", 32'h8000_0002, 2'd1, 1'b1, 0, 32'h8001_1234, 32'h0000_8001);
        load_case("lh_ofs0", 32'h9000_0000, 2'd1, 1'b0, 1, 32'h0000_F00F, 32'hFFFF_F00F);
        load_case("lbu_ofs1", 32'h1000_0001, 2'd0, 1'b1, 2, 32'h0000_9A00, 32'h0000_009A);
        load_case("lb_pos", 32'h8000_0000, 2'd0, 1'b0, 0, 32'hFFFF_FF7F, 32'h0000_007F);

        // Response routed raw to the AGU.
        drive_cmd(32'h9000_0010, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
        tick();
        agu_icb_cmd_valid = 1'b0;
        tgt_icb_rsp_excl_ok[1] = 1'b1;
        respond(1, 32'h1234_5678, 1'b1);
        chk("b2a_valid", 32'(agu_icb_rsp_valid), 32'd1);
        chk("b2a_rdata", agu_icb_rsp_rdata, 32'h1234_5678);
        chk("b2a_err", 32'(agu_icb_rsp_err), 32'd1);
        chk("b2a_excl_ok", 32'(agu_icb_rsp_excl_ok), 32'd1);
        chk("b2a_lsu_idle", 32'(lsu_o_valid), 32'd0);
        chk("b2a_rsp_ready", 32'(tgt_icb_rsp_ready), 32'b010);
        tick();
        tgt_icb_rsp_valid = '0; tgt_icb_rsp_err = '0; tgt_icb_rsp_excl_ok = '0;

        // Store with bus error.
        agu_icb_cmd_wdata = 32'hDEAD_BEEF;
        agu_icb_cmd_wmask = 4'hF;
        drive_cmd(32'h8000_0010, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
        chk("st_bcast_wdata", tgt_icb_cmd_wdata[95:64], 32'hDEAD_BEEF);
        chk("st_bcast_wmask", 32'(tgt_icb_cmd_wmask[3:0]), 32'hF);
        chk("st_bcast_read", 32'(tgt_icb_cmd_read), 32'd0);
        tick();
        agu_icb_cmd_valid = 1'b0;
        expect_lsu(32'h0, 1'b1, 1'b0, 32'h8000_0010, 1'b1);
        respond(0, 32'h5555_5555, 1'b1);
        for (int i = 0; i < 20 && !lsu_o_valid; i++) tick();
        check_lsu("st_err");
        tick();
        tgt_icb_rsp_valid = '0; tgt_icb_rsp_err = '0;

        // Asynchronous reset mid-flight discards the entry.
        drive_cmd(32'h9000_0020, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        agu_icb_cmd_valid = 1'b0;
        #1;
        chk("mid_active", 32'(lsu_active), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_active", 32'(lsu_active), 32'd0);
        tick();
        rst_n = 1'b1;
        respond(1, 32'h7777_7777, 1'b0);
        chk("post_rst_rsp_ready", 32'(tgt_icb_rsp_ready), 32'd0);
        chk("post_rst_lsu_idle", 32'(lsu_o_valid), 32'd0);
        tgt_icb_rsp_valid = '0;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/e203_lsu_rgn_router.md
# e203_lsu_rgn_router

Parametrised successor of the LSU control path. It accepts AGU ICB commands and decodes each address against NTGT-1 programmable regions, with one default target. Commands go to NTGT ICB target ports, and up to OTF_DEPTH transactions are tracked in flight. Responses return strictly in order, either to the AGU or to the write-back interface, with load alignment and sign extension. The block sits between the EXU AGU and the ITCM/DTCM/BIU/extension targets.

## Interface
- NTGT, 3: number of target ports (>=2); index NTGT-1 is the default (BIU) target
- OTF_DEPTH, 2: max outstanding transactions (>=1, any integer)
- AW, 32: address width
- ITAG_W, 1: instruction tag width
- Data width fixed at 32 (XLEN); wmask 4 bits
- clk  in  1  clock (single clock domain)
- rst_n  in  1  asynchronous, active-low reset
- tgt_rgn_base / tgt_rgn_mask  in  NTGT*AW each  per-target base/mask; slice NTGT-1 ignored
- lsu_active  out  1  clock-gate request
- agu_icb_cmd_valid/ready  in/out  1  command handshake
- agu_icb_cmd_addr in AW; _read in 1; _wdata in 32; _wmask in 4; _lock, _excl in 1; _size in 2; _back2agu, _usign in 1; _itag in ITAG_W
- agu_icb_rsp_valid/ready  out/in  1; agu_icb_rsp_err, _excl_ok out 1; agu_icb_rsp_rdata out 32
- lsu_o_valid/ready  out/in  1; lsu_o_wbck_wdat out 32; lsu_o_wbck_itag out ITAG_W; lsu_o_wbck_err, lsu_o_cmt_ld, lsu_o_cmt_st, lsu_o_cmt_buserr out 1; lsu_o_cmt_badaddr out AW
- tgt_icb_cmd_valid out NTGT; tgt_icb_cmd_ready in NTGT; tgt_icb_cmd_addr out NTGT*AW; _read, _lock, _excl out NTGT; _wdata out NTGT*32; _wmask out NTGT*4; _size out NTGT*2
- tgt_icb_rsp_valid in NTGT; tgt_icb_rsp_ready out NTGT; _err, _excl_ok in NTGT; _rdata in NTGT*32

## Operation
- Target decode: sel = lowest i in 0..NTGT-2 with (addr & mask_i) == (base_i & mask_i); otherwise sel = NTGT-1.
- Command payload is broadcast to all targets; only tgt_icb_cmd_valid[sel] follows agu_icb_cmd_valid.
- agu_icb_cmd_ready = tgt_icb_cmd_ready[sel] & ~full.
  - No push-on-pop bypass: when full, ready stays 0 even while a pop occurs.
- On command handshake, push entry {sel, back2agu, usign, size, addr[1:0], read, itag, addr} into the outstanding FIFO.
- Response routing:
  - Only the head entry's target is accepted: tgt_icb_rsp_ready[h] = destination ready; all other rsp_ready = 0.
  - Destination is the AGU if head.back2agu, else lsu_o.
  - Destination valid = ~empty & tgt_icb_rsp_valid[h]; pop on handshake.
- AGU destination: rdata, err and excl_ok pass through raw.
- lsu_o destination:
  - wbck_itag = head.itag; wbck_err = cmt_buserr = err; cmt_ld = head.read; cmt_st = ~head.read; cmt_badaddr = head.addr.
  - Load data = rdata >> (8*head.addr[1:0]). Size 0: bits[7:0]; size 1: bits[15:0]; size 2: full word.
  - Byte and halfword loads are sign-extended unless head.usign.
  - Stores: wbck_wdat = 0.
- Responses from non-head targets, and any rsp_valid while the FIFO is empty, are held off (ready 0), never dropped.
- lsu_active = agu_icb_cmd_valid | ~empty.

## Timing
- Reset: FIFO empty, pointers and count 0.
  - agu/lsu_o rsp valids 0; all tgt_icb_rsp_ready 0.
  - Command-path outputs are combinational from inputs.
- Command path and response path are zero-latency combinational. The only state is the FIFO.
- Earliest response is the cycle after the command handshake. A same-cycle response to an unpushed command is never accepted.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Pointers wrap modulo OTF_DEPTH (non-power-of-2 supported). Count width is clog2(OTF_DEPTH+1).
- Handshake stability: destination valid and data hold while the destination ready is low.
- Asynchronous reset mid-transaction discards all entries. Targets must also be reset.

## Structure
- Shared package e203_lsu_pkg holds:
  - ICB size encodings (BYTE=0, HALF=1, WORD=2)
  - outstanding-entry field widths and the target-index width clog2(NTGT)
  - load-extend function
- One sub-module: e203_lsu_otf_fifo, a generic synchronous FIFO (width and depth parameters, full/empty/count, asynchronous active-low reset).

## Test plan
- Region decode: base0=0x8000_0000, mask0=0xFFFF_0000; load 0x8000_0004 -> tgt_icb_cmd_valid=3'b001. Load 0x1000_0000 -> 3'b100 (default).
- Ordering: load to tgt0, then load to tgt1; tgt1 responds first -> tgt1 rsp_ready=0 until tgt0 response pops; lsu_o sees tgt0 data, then tgt1 data.
- Full back-pressure with OTF_DEPTH=2: two loads outstanding -> agu_icb_cmd_ready=0 with target ready=1. Third command is accepted the cycle after the first pop.
- Load extend:
  - lb at addr[1:0]=3, rdata=0x80xx_xxxx -> wdat=0xFFFF_FF80.
  - lhu at addr[1:0]=2, rdata=0x8001_xxxx -> wdat=0x0000_8001.
- back2agu: AMO read with back2agu=1, rdata=0x1234_5678, err=1 -> agu_icb_rsp valid with raw data and err=1; lsu_o_valid stays 0.
- Bus error store: store to 0x8000_0010 with err=1 -> lsu_o_cmt_st=1, lsu_o_cmt_buserr=1, lsu_o_cmt_badaddr=0x8000_0010. Reset asserted mid-flight -> empty, lsu_active=0 once agu_icb_cmd_valid=0.
